// File: rtl/layer_pkg.sv
// rtl/layer_pkg.sv - shared types and defaults for the layer parameter path
package layer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    COMMIT = 2'd1,
    FLUSH  = 2'd2
  } loader_state_t;

endpackage

// File: rtl/layer_param_loader.sv
// rtl/layer_param_loader.sv - framed parameter stream into shadow buffer, atomic commit to Layer buses
module layer_param_loader
  import layer_pkg::*;
#(
  parameter int IN_N       = 4,
  parameter int OUT_N      = 2,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [DATA_WIDTH-1:0]             s_data,
  input  logic                              s_last,
  output logic [OUT_N*IN_N*DATA_WIDTH-1:0]  weights,
  output logic [OUT_N*DATA_WIDTH-1:0]       biases,
  output logic                              params_valid,
  output logic                              commit,
  output logic                              load_err
);

  localparam int NW    = OUT_N * IN_N;
  localparam int TOTAL = NW + OUT_N;
  localparam int CW    = $clog2(TOTAL);
  localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

  loader_state_t                   r_state;
  loader_state_t                   w_state_nxt;
  logic [CW-1:0]                   r_cnt;
  logic [CW-1:0]                   w_cnt_nxt;
  logic [DATA_WIDTH-1:0]           r_shadow [TOTAL];
  logic [OUT_N*IN_N*DATA_WIDTH-1:0] r_weights;
  logic [OUT_N*DATA_WIDTH-1:0]     r_biases;
  logic                            r_params_valid;
  logic                            r_commit;
  logic                            r_load_err;
  logic                            r_s_ready;
  logic                            w_beat;
  logic                            w_shadow_we;
  logic                            w_commit_nxt;
  logic                            w_load_err_nxt;
  logic                            w_s_ready_nxt;

  assign w_beat = s_valid && r_s_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD:    if (w_beat && r_cnt == LAST_IDX) w_state_nxt = s_last ? COMMIT : FLUSH;
      COMMIT:  w_state_nxt = LOAD;
      FLUSH:   if (w_beat && s_last) w_state_nxt = LOAD;
      default: w_state_nxt = LOAD;
    endcase
  end

  // s_ready is registered from the next state, so it never depends on s_valid in the same cycle
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_shadow_we    = 1'b0;
    w_commit_nxt   = 1'b0;
    w_load_err_nxt = 1'b0;
    w_s_ready_nxt  = (w_state_nxt != COMMIT);
    case (r_state)
      LOAD: begin
        if (w_beat) begin
          w_shadow_we = 1'b1;
          if (r_cnt == LAST_IDX) begin
            w_cnt_nxt      = '0;
            w_load_err_nxt = !s_last;
          end else if (s_last) begin
            w_cnt_nxt      = '0;
            w_load_err_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      COMMIT:  w_commit_nxt = 1'b1;
      FLUSH:   if (w_beat && s_last) w_cnt_nxt = '0;
      default: w_cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_weights      <= '0;
      r_biases       <= '0;
      r_params_valid <= 1'b0;
      r_commit       <= 1'b0;
      r_load_err     <= 1'b0;
      r_s_ready      <= 1'b1;
      for (int k = 0; k < TOTAL; k++) r_shadow[k] <= '0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_commit   <= w_commit_nxt;
      r_load_err <= w_load_err_nxt;
      r_s_ready  <= w_s_ready_nxt;
      if (w_shadow_we) r_shadow[r_cnt] <= s_data;
      if (r_state == COMMIT) begin
        for (int k = 0; k < NW; k++)    r_weights[k*DATA_WIDTH +: DATA_WIDTH] <= r_shadow[k];
        for (int k = 0; k < OUT_N; k++) r_biases[k*DATA_WIDTH +: DATA_WIDTH]  <= r_shadow[NW+k];
        r_params_valid <= 1'b1;
      end
    end
  end

  assign s_ready      = r_s_ready;
  assign weights      = r_weights;
  assign biases       = r_biases;
  assign params_valid = r_params_valid;
  assign commit       = r_commit;
  assign load_err     = r_load_err;

endmodule

// File: tb/tb_layer_param_loader.sv
// tb/tb_layer_param_loader.sv - directed self-checking bench for layer_param_loader
module tb_layer_param_loader;

  localparam int IN_N  = 2;
  localparam int OUT_N = 2;
  localparam int DW    = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      s_valid;
  logic                      s_ready;
  logic [DW-1:0]             s_data;
  logic                      s_last;
  logic [OUT_N*IN_N*DW-1:0]  weights;
  logic [OUT_N*DW-1:0]       biases;
  logic                      params_valid;
  logic                      commit;
  logic                      load_err;

  int n_vec  = 0;
  int n_miss = 0;
  int n_commit = 0;
  int n_err    = 0;
  int c0, e0;

  layer_param_loader #(.IN_N(IN_N), .OUT_N(OUT_N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .weights(weights), .biases(biases), .params_valid(params_valid),
    .commit(commit), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      n_commit += int'(commit);
      n_err    += int'(load_err);
    end
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat's edge.
  task automatic send(input logic [DW-1:0] d, input logic l);
    int wait_cycles = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (!s_ready) check_vec("send_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input int gaps);
    for (int k = 0; k < 6; k++) begin
      send(base + DW'(k), k == 5);
      if (gaps != 0 && k != 5) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    @(negedge clk);
    do_reset();
    check_vec("rst_weights", 64'(weights), 64'd0);
    check_vec("rst_biases", 64'(biases), 64'd0);
    check_vec("rst_pvalid", 64'(params_valid), 64'd0);
    check_vec("rst_commit", 64'(commit), 64'd0);
    check_vec("rst_err", 64'(load_err), 64'd0);
    check_vec("rst_ready", 64'(s_ready), 64'd1);

    // Normal load 1,-2,3,-4,5,-6 with valid held high
    c0 = n_commit;
    send(8'd1, 1'b0); send(8'hFE, 1'b0); send(8'd3, 1'b0);
    send(8'hFC, 1'b0); send(8'd5, 1'b0); send(8'hFA, 1'b1);
    check_vec("norm_commit_e0", 64'(commit), 64'd0);
    check_vec("norm_ready_bubble", 64'(s_ready), 64'd0);
    check_vec("norm_weights_early", 64'(weights), 64'd0);
    @(negedge clk);
    check_vec("norm_commit_e1", 64'(commit), 64'd1);
    check_vec("norm_pvalid", 64'(params_valid), 64'd1);
    check_vec("norm_ready_back", 64'(s_ready), 64'd1);
    check_vec("norm_weights", 64'(weights), 64'hFC03FE01);
    check_vec("norm_biases", 64'(biases), 64'hFA05);
    @(negedge clk);
    check_vec("norm_commit_e2", 64'(commit), 64'd0);
    check_vec("norm_commit_cnt", 64'(n_commit - c0), 64'd1);

    // Same frame with valid toggled every other cycle
    c0 = n_commit; e0 = n_err;
    send(8'd1, 1'b0); @(negedge clk); send(8'hFE, 1'b0); @(negedge clk);
    send(8'd3, 1'b0); @(negedge clk); send(8'hFC, 1'b0); @(negedge clk);
    send(8'd5, 1'b0); @(negedge clk); send(8'hFA, 1'b1);
    repeat (3) @(negedge clk);
    check_vec("bub_weights", 64'(weights), 64'hFC03FE01);
    check_vec("bub_biases", 64'(biases), 64'hFA05);
    check_vec("bub_commit_cnt", 64'(n_commit - c0), 64'd1);
    check_vec("bub_err_cnt", 64'(n_err - e0), 64'd0);

    // Short frame of 3 words
    c0 = n_commit; e0 = n_err;
    send(8'h0A, 1'b0); send(8'h14, 1'b0); send(8'h1E, 1'b1);
    check_vec("short_err_pulse", 64'(load_err), 64'd1);
    @(negedge clk);
    check_vec("short_err_drop", 64'(load_err), 64'd0);
    check_vec("short_weights", 64'(weights), 64'hFC03FE01);
    check_vec("short_biases", 64'(biases), 64'hFA05);
    check_vec("short_pvalid", 64'(params_valid), 64'd1);
    send_frame(8'h11, 0);
    repeat (3) @(negedge clk);
    check_vec("short_next_weights", 64'(weights), 64'h14131211);
    check_vec("short_next_biases", 64'(biases), 64'h1615);
    check_vec("short_commit_cnt", 64'(n_commit - c0), 64'd1);
    check_vec("short_err_cnt", 64'(n_err - e0), 64'd1);

    // Long frame of 8 words
    c0 = n_commit; e0 = n_err;
    for (int k = 0; k < 6; k++) send(8'h21 + 8'(k), 1'b0);
    check_vec("long_err_pulse", 64'(load_err), 64'd1);
    check_vec("long_flush_ready", 64'(s_ready), 64'd1);
    send(8'h27, 1'b0);
    check_vec("long_err_once", 64'(load_err), 64'd0);
    send(8'h28, 1'b1);
    repeat (3) @(negedge clk);
    check_vec("long_weights", 64'(weights), 64'h14131211);
    check_vec("long_biases", 64'(biases), 64'h1615);
    check_vec("long_commit_cnt", 64'(n_commit - c0), 64'd0);
    check_vec("long_err_cnt", 64'(n_err - e0), 64'd1);
    send_frame(8'h31, 1);
    repeat (3) @(negedge clk);
    check_vec("long_next_weights", 64'(weights), 64'h34333231);
    check_vec("long_next_biases", 64'(biases), 64'h3635);

    // Reset in the middle of a frame
    for (int k = 0; k < 4; k++) send(8'h40 + 8'(k), 1'b0);
    do_reset();
    check_vec("mid_rst_weights", 64'(weights), 64'd0);
    check_vec("mid_rst_pvalid", 64'(params_valid), 64'd0);
    c0 = n_commit; e0 = n_err;
    for (int k = 0; k < 6; k++) send(8'h07, k == 5);
    repeat (3) @(negedge clk);
    check_vec("mid_weights", 64'(weights), 64'h07070707);
    check_vec("mid_biases", 64'(biases), 64'h0707);
    check_vec("mid_commit_cnt", 64'(n_commit - c0), 64'd1);
    check_vec("mid_err_cnt", 64'(n_err - e0), 64'd0);
    check_vec("mid_pvalid", 64'(params_valid), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
